// File: rtl/kcpsmx3_inc.sv
// Shared RojoBlaze definitions: I/O port geometry plus the interrupt controller's
// state encoding and register offsets.
package kcpsmx3_inc;

    localparam int PORT_WIDTH = 8;
    localparam int PORT_DEPTH = 8;

    // Source IDs are reported in a 3-bit field of the VEC register.
    localparam int IRQ_ID_W = 3;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_SVC  = 2'd2
    } irq_state_t;

    localparam logic [1:0] IRQ_OFS_MASK = 2'd0;
    localparam logic [1:0] IRQ_OFS_PEND = 2'd1;
    localparam logic [1:0] IRQ_OFS_VEC  = 2'd2;
    localparam logic [1:0] IRQ_OFS_CTRL = 2'd3;

endpackage

// File: rtl/rojo_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping
// at N-1.
module rojo_rr_arbiter
    import kcpsmx3_inc::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]        req,
    input  logic [IRQ_ID_W-1:0] ptr,
    output logic [IRQ_ID_W-1:0] gnt_id,
    output logic                gnt_valid
);

    // Scan from the farthest offset down so the closest hit to ptr wins.
    always_comb begin
        gnt_id    = '0;
        gnt_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                gnt_id    = IRQ_ID_W'((int'(ptr) + i) % N);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rojo_irq_ctrl.sv
// Interrupt controller multiplexing NUM_SRC edge-triggered sources onto the
// RojoBlaze interrupt line, with round-robin arbitration and EOI handshake.
module rojo_irq_ctrl
    import kcpsmx3_inc::*;
#(
    parameter int                    NUM_SRC   = 8,
    parameter logic [PORT_DEPTH-1:0] BASE_PORT = 8'hF0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SRC-1:0]    irq_src,
    input  logic [PORT_DEPTH-1:0] port_id,
    input  logic                  write_strobe,
    input  logic                  read_strobe,
    input  logic [PORT_WIDTH-1:0] out_port,
    input  logic                  interrupt_ack,
    output logic                  interrupt,
    output logic [PORT_WIDTH-1:0] rd_data,
    output logic                  rd_hit
);

    irq_state_t            state_q, state_d;
    logic [NUM_SRC-1:0]    irq_src_q, irq_src_d;
    logic [NUM_SRC-1:0]    mask_q, mask_d;
    logic [NUM_SRC-1:0]    pend_q, pend_d;
    logic                  ctrl_q, ctrl_d;
    logic                  in_service_q, in_service_d;
    logic [IRQ_ID_W-1:0]   id_q, id_d;
    logic [IRQ_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IRQ_ID_W-1:0]   win_q, win_d;

    logic [NUM_SRC-1:0]    pend_set, pend_clr, elig;
    logic [1:0]            ofs;
    logic                  wr_en, eoi;
    logic [IRQ_ID_W-1:0]   gnt_id;
    logic                  gnt_valid;

    // Reads are side-effect free, so the core's read strobe carries no information here.
    logic                  unused_read_strobe;
    assign unused_read_strobe = read_strobe;

    assign rd_hit    = (port_id[PORT_DEPTH-1:2] == BASE_PORT[PORT_DEPTH-1:2]);
    assign ofs       = port_id[1:0];
    assign wr_en     = write_strobe & rd_hit;
    assign eoi       = wr_en && (ofs == IRQ_OFS_VEC);
    assign pend_set  = irq_src & ~irq_src_q;
    assign elig      = pend_q & mask_q & {NUM_SRC{ctrl_q}};
    assign interrupt = (state_q == IRQ_REQ);

    rojo_rr_arbiter #(.N(NUM_SRC)) u_arb (
        .req       (elig),
        .ptr       (rr_ptr_q),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_d      = state_q;
        irq_src_d    = irq_src;
        mask_d       = mask_q;
        ctrl_d       = ctrl_q;
        in_service_d = in_service_q;
        id_d         = id_q;
        rr_ptr_d     = rr_ptr_q;
        win_d        = win_q;
        pend_clr     = '0;

        if (wr_en) begin
            case (ofs)
                IRQ_OFS_MASK: mask_d   = out_port[NUM_SRC-1:0];
                IRQ_OFS_PEND: pend_clr = out_port[NUM_SRC-1:0];
                IRQ_OFS_CTRL: ctrl_d   = out_port[0];
                default: ;
            endcase
        end

        // win is frozen once REQ is entered; later MASK/PEND edits cannot retract it.
        case (state_q)
            IRQ_IDLE: begin
                if (gnt_valid) begin
                    win_d   = gnt_id;
                    state_d = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                if (interrupt_ack) begin
                    pend_clr[win_q] = 1'b1;
                    id_d            = win_q;
                    in_service_d    = 1'b1;
                    rr_ptr_d        = (win_q == IRQ_ID_W'(NUM_SRC - 1)) ? '0 : win_q + 1'b1;
                    state_d         = IRQ_SVC;
                end
            end
            IRQ_SVC: begin
                if (eoi) begin
                    in_service_d = 1'b0;
                    state_d      = IRQ_IDLE;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase

        // A fresh edge outranks any clear landing in the same cycle.
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IRQ_IDLE;
            irq_src_q    <= '0;
            mask_q       <= '0;
            pend_q       <= '0;
            ctrl_q       <= 1'b0;
            in_service_q <= 1'b0;
            id_q         <= '0;
            rr_ptr_q     <= '0;
            win_q        <= '0;
        end else begin
            state_q      <= state_d;
            irq_src_q    <= irq_src_d;
            mask_q       <= mask_d;
            pend_q       <= pend_d;
            ctrl_q       <= ctrl_d;
            in_service_q <= in_service_d;
            id_q         <= id_d;
            rr_ptr_q     <= rr_ptr_d;
            win_q        <= win_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_hit) begin
            case (ofs)
                IRQ_OFS_MASK: rd_data[NUM_SRC-1:0] = mask_q;
                IRQ_OFS_PEND: rd_data[NUM_SRC-1:0] = pend_q;
                IRQ_OFS_VEC:  rd_data = {in_service_q, 4'b0000, id_q};
                IRQ_OFS_CTRL: rd_data[0] = ctrl_q;
                default:      rd_data = '0;
            endcase
        end
    end

endmodule
